mem_bus_pattern_master: RTL and testbench

Simulation-side initiator for the single-cycle memory bus: addr, write data, read data, write_en, with read data registered one cycle after the address.
- On start, it writes a parameterised word pattern into a contiguous address window.
- It then reads the window back and compares every word against the pattern.
- It reports done, pass and a mismatch count.
- It drives RAM-like responders in testbenches and bus-level self-checks.

---
 rtl/mem_bus_pattern_master_pkg.sv | 28 ++
 rtl/mem_bus_pattern_master.sv | 129 ++++++++++++
 tb/tb_mem_bus_pattern_master.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pattern_master_pkg.sv
// Purpose: shared state encoding and pattern-word extraction for the memory bus pattern master.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// The state enum and the pattern_word() function live here so that testers
// checking the same pattern derive identical words.
package mem_bus_pattern_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Word `index` of a packed pattern: (content >> index*wsize) masked to wsize bits.
  // Shifts past the 32-bit pattern naturally yield zero words.
  function automatic logic [63:0] pattern_word(input logic [31:0]  content,
                                               input int unsigned index,
                                               input int unsigned wsize);
    logic [63:0] w;
    w = {32'h0, content} >> (index * wsize);
    if (wsize < 64) w = w & ((64'd1 << wsize) - 64'd1);
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_pattern_master.sv
// Purpose: writes a fixed word pattern into an address window, reads it back and counts mismatches.
// Latency: done visible after edge 2*array_size+1 counted from the start edge (edge 0).
// Backpressure: none; the bus is single-cycle, start is ignored while busy.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous active-low reset
//   start          in   one-cycle pulse, begins a write-then-verify pass
//   addr           out  bus address (base_addr + index, wraps modulo 2^addr_size)
//   data_out       out  write data (zero outside WRITE)
//   data_in        in   read data, valid one cycle after addr
//   write_en       out  bus write strobe (WRITE state only)
//   busy           out  pass in progress
//   done           out  pass finished; held until next start or reset
//   pass           out  valid with done; high iff mismatch_count == 0
//   mismatch_count out  saturating count of words that read back wrong
module mem_bus_pattern_master
  import mem_bus_pattern_master_pkg::*;
#(
  parameter int          base_addr     = 0,
  parameter int          addr_size     = 16,
  parameter int          word_size     = 16,
  parameter int          array_size    = 2,
  parameter logic [31:0] array_content = 32'hFFFFFFFF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic [addr_size-1:0]             addr,
  output logic [word_size-1:0]             data_out,
  input  logic [word_size-1:0]             data_in,
  output logic                             write_en,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [$clog2(array_size+1)-1:0]  mismatch_count
);

  localparam int                   IW    = $clog2(array_size + 1);
  localparam logic [IW-1:0]        LAST  = IW'(array_size - 1);
  localparam logic [IW-1:0]        SAT   = IW'(array_size);
  localparam logic [addr_size-1:0] BASE  = addr_size'(base_addr);
  localparam logic [word_size-1:0] WORD0 = word_size'(pattern_word(array_content, 0, word_size));

  state_t          state;
  logic [IW-1:0]   idx;   // issue pointer (wi in WRITE, ri in READ)
  logic [IW-1:0]   ci;    // compare pointer, one behind the read issue pointer

  logic [word_size-1:0] next_word;
  logic [word_size-1:0] cmp_word;
  logic [IW-1:0]        mm_next;

  always_comb begin
    next_word = word_size'(pattern_word(array_content, 32'(idx) + 32'd1, word_size));
    cmp_word  = word_size'(pattern_word(array_content, 32'(ci), word_size));
    mm_next   = mismatch_count;
    if (data_in != cmp_word && mismatch_count != SAT) mm_next = mismatch_count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      idx            <= '0;
      ci             <= '0;
      addr           <= '0;
      data_out       <= '0;
      write_en       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state          <= WRITE;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            idx            <= '0;
            ci             <= '0;
            addr           <= BASE;
            data_out       <= WORD0;
            write_en       <= 1'b1;
          end
        end
        WRITE: begin
          if (idx == LAST) begin
            // last word has been on the bus for one cycle; restart at base for reads
            state    <= READ;
            write_en <= 1'b0;
            data_out <= '0;
            addr     <= BASE;
            idx      <= '0;
          end else begin
            idx      <= idx + 1'b1;
            addr     <= BASE + addr_size'(idx + 1'b1);
            data_out <= next_word;
          end
        end
        READ: begin
          // read data trails the address by one cycle, so the first READ edge has nothing to compare
          if (idx != '0) begin
            mismatch_count <= mm_next;
            ci             <= ci + 1'b1;
          end
          if (idx == LAST) begin
            state <= DRAIN;
          end else begin
            idx  <= idx + 1'b1;
            addr <= BASE + addr_size'(idx + 1'b1);
          end
        end
        DRAIN: begin
          mismatch_count <= mm_next;
          pass           <= (mm_next == '0);
          done           <= 1'b1;
          busy           <= 1'b0;
          addr           <= '0;
          data_out       <= '0;
          state          <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_pattern_master.sv
module tb_mem_bus_pattern_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] addr_a, dout_a, din_a, addr_b, dout_b, din_b;
  logic        we_a, busy_a, done_a, pass_a;
  logic        we_b, busy_b, done_b, pass_b;
  logic [1:0]  mm_a;
  logic [0:0]  mm_b;

  mem_bus_pattern_master #(
    .base_addr(16'h0010), .addr_size(16), .word_size(16),
    .array_size(2), .array_content(32'h1234ABCD)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .addr(addr_a), .data_out(dout_a),
    .data_in(din_a), .write_en(we_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .mismatch_count(mm_a)
  );

  mem_bus_pattern_master #(
    .base_addr(16'hFFFF), .addr_size(16), .word_size(16),
    .array_size(1), .array_content(32'h0000BEEF)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .addr(addr_b), .data_out(dout_b),
    .data_in(din_b), .write_en(we_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .mismatch_count(mm_b)
  );

  // One-cycle RAM responders with optional read corruption on A
  logic [15:0] mem_a [256];
  logic [15:0] flip_a [256];
  logic [15:0] mem_b [256];
  bit          stuck_a = 1'b0;
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_b[$];

  always @(posedge clk) begin
    if (we_a) begin
      mem_a[addr_a[7:0]] <= dout_a;
      wlog_a.push_back({addr_a, dout_a});
    end
    din_a <= stuck_a ? 16'h0000 : (mem_a[addr_a[7:0]] ^ flip_a[addr_a[7:0]]);
    if (we_b) begin
      mem_b[addr_b[7:0]] <= dout_b;
      wlog_b.push_back({addr_b, dout_b});
    end
    din_b <= mem_b[addr_b[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;
  int lat_a;
  logic busy0_a, done0_a;

  localparam logic [31:0] CONT_A = 32'h1234ABCD;

  function automatic logic [15:0] ref_word(input logic [31:0] c, input int i);
    return 16'((c >> (16 * i)) & 32'h0000FFFF);
  endfunction

  // Expected mismatches: words whose read-back value differs from what was written
  function automatic int ref_mismatches();
    int n;
    logic [15:0] w, rd;
    n = 0;
    for (int i = 0; i < 2; i++) begin
      w  = ref_word(CONT_A, i);
      rd = stuck_a ? 16'h0000 : (w ^ flip_a[16 + i]);
      if (rd != w) n++;
    end
    return n;
  endfunction

  // Pulse start on A at edge E0, optionally re-pulse at edge E<extra_k>, wait for done
  task automatic run_a(input int extra_k);
    lat_a = -1;
    wlog_a.delete();
    @(negedge clk);
    start_a = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      start_a = (k + 1 == extra_k);
      if (k == 0) begin
        busy0_a = busy_a;
        done0_a = done_a;
      end
      if (done_a) begin
        lat_a = k;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    start_a = 1'b1;   // reset must win over start
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (we_a !== 1'b0)   $display("FAIL reset_we_a: got %b want 0", we_a);     else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy_a: got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done_a: got %b want 0", done_a); else n_pass++;
    n_checks++; if (pass_a !== 1'b0) $display("FAIL reset_pass_a: got %b want 0", pass_a); else n_pass++;
    n_checks++; if (mm_a !== 2'd0)   $display("FAIL reset_mm_a: got %0d want 0", mm_a);    else n_pass++;
    n_checks++; if (addr_a !== 16'h0 || dout_a !== 16'h0)
      $display("FAIL reset_bus_a: got addr %h data %h want 0 0", addr_a, dout_a); else n_pass++;
    n_checks++; if ({we_b, busy_b, done_b, pass_b, mm_b} !== 5'b0 || addr_b !== 16'h0)
      $display("FAIL reset_b: got flags %b addr %h want 0", {we_b, busy_b, done_b, pass_b, mm_b}, addr_b); else n_pass++;
    @(negedge clk);
    start_a = 1'b0;
    reset   = 1'b1;
  endtask

  task automatic test_pass_run(input string name, input bit stuck,
                               input logic [15:0] f0, input logic [15:0] f1, input int extra_k);
    int          exp_mm;
    logic [31:0] got, want;
    stuck_a    = stuck;
    flip_a[16] = f0;
    flip_a[17] = f1;
    exp_mm     = ref_mismatches();
    run_a(extra_k);
    n_checks++; if (lat_a !== 5) $display("FAIL %s latency: got %0d want 5", name, lat_a); else n_pass++;
    n_checks++; if (busy0_a !== 1'b1 || done0_a !== 1'b0)
      $display("FAIL %s start_flags: got busy %b done %b want 1 0", name, busy0_a, done0_a); else n_pass++;
    n_checks++; if (pass_a !== (exp_mm == 0))
      $display("FAIL %s pass: got %b want %b", name, pass_a, exp_mm == 0); else n_pass++;
    n_checks++; if (int'(mm_a) !== exp_mm)
      $display("FAIL %s mismatch_count: got %0d want %0d", name, mm_a, exp_mm); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || we_a !== 1'b0 || addr_a !== 16'h0)
      $display("FAIL %s idle_bus: got busy %b we %b addr %h want 0 0 0", name, busy_a, we_a, addr_a); else n_pass++;
    n_checks++; if (wlog_a.size() !== 2)
      $display("FAIL %s write_count: got %0d want 2", name, wlog_a.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      want = {16'h0010 + 16'(i), ref_word(CONT_A, i)};
      got  = (i < wlog_a.size()) ? wlog_a[i] : 32'hFFFFFFFF;
      n_checks++; if (got !== want)
        $display("FAIL %s write%0d: got %h want %h", name, i, got, want); else n_pass++;
    end
    stuck_a    = 1'b0;
    flip_a[16] = 16'h0;
    flip_a[17] = 16'h0;
  endtask

  task automatic test_nominal();
    test_pass_run("nominal", 1'b0, 16'h0, 16'h0, -1);
  endtask

  task automatic test_stuck();
    test_pass_run("stuck", 1'b1, 16'h0, 16'h0, -1);
  endtask

  task automatic test_corrupt();
    test_pass_run("corrupt", 1'b0, 16'h0, 16'h0001, -1);
  endtask

  task automatic test_start_busy();
    test_pass_run("start_busy", 1'b0, 16'h0, 16'h0, 2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;   // E0
    start_a = 1'b0;
    @(posedge clk); #1;   // E1
    @(posedge clk); #1;   // E2: now in READ
    reset = 1'b0;
    @(posedge clk); #1;   // E3: reset sampled
    n_checks++; if (we_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 || addr_a !== 16'h0)
      $display("FAIL reset_mid: got we %b busy %b done %b addr %h want 0 0 0 0", we_a, busy_a, done_a, addr_a);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    test_pass_run("after_reset", 1'b0, 16'h0, 16'h0, -1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [15:0] f0, f1;
      bit          st;
      st = ($urandom_range(0, 3) == 0);
      f0 = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      f1 = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      test_pass_run($sformatf("random%0d", it), st, f0, f1, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : -1);
    end
  endtask

  task automatic test_boundary();
    int lat;
    bit wrapped;
    lat     = -1;
    wrapped = 1'b0;
    wlog_b.delete();
    @(negedge clk);
    start_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      if (busy_b && addr_b !== 16'hFFFF) wrapped = 1'b1;
      if (done_b) begin
        lat = k;
        break;
      end
    end
    n_checks++; if (lat !== 3) $display("FAIL boundary latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (pass_b !== 1'b1 || mm_b !== 1'b0)
      $display("FAIL boundary result: got pass %b mm %0d want 1 0", pass_b, mm_b); else n_pass++;
    n_checks++; if (wrapped !== 1'b0) $display("FAIL boundary addr_wrap: got 1 want 0"); else n_pass++;
    n_checks++; if (wlog_b.size() !== 1 || wlog_b[0] !== 32'hFFFFBEEF)
      $display("FAIL boundary write: got %0d writes first %h want 1 ffffbeef", wlog_b.size(),
               (wlog_b.size() > 0) ? wlog_b[0] : 32'h0); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i]  = 16'h0;
      flip_a[i] = 16'h0;
      mem_b[i]  = 16'h0;
    end
    test_reset();
    test_nominal();
    test_stuck();
    test_corrupt();
    test_start_busy();
    test_reset_mid();
    test_random();
    test_boundary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
